// File: rtl/rl_fifo_1r1w_fwft.sv
// -----------------------------------------------------------------------------
// rl_fifo_1r1w_fwft
//
// Show-ahead (first-word-fall-through) synchronous FIFO built around an
// inferred 1R1W RAM with a registered read port and no read/write bypass.
// Words written on the slave side land in the RAM.  A fetch engine reads them
// out one per cycle into a 2-entry output buffer (OB).  The OB absorbs the
// one-cycle RAM read latency so the master side sees a registered head word
// and can sustain one word per cycle.
//
// Parameters
//   ABITS      RAM address bits, RAM depth = 2**ABITS words
//   DBITS      data word width
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset (discards all content)
//   clear_i    synchronous active-high flush (discards all content)
//   s_valid_i  write side: data valid
//   s_data_i   write side: data word
//   s_ready_o  write side: FIFO can accept (RAM not full, not in reset/flush)
//   m_valid_o  read side: head word valid
//   m_data_o   read side: head word
//   m_ready_i  read side: consumer accepts head word
//   level_o    total words held: RAM + in-flight read + OB
// -----------------------------------------------------------------------------
module rl_fifo_1r1w_fwft #(
  parameter int unsigned ABITS = 4,
  parameter int unsigned DBITS = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             s_valid_i,
  input  logic [DBITS-1:0] s_data_i,
  output logic             s_ready_o,
  output logic             m_valid_o,
  output logic [DBITS-1:0] m_data_o,
  input  logic             m_ready_i,
  output logic [ABITS+1:0] level_o
);

  localparam int unsigned DEPTH = 2 ** ABITS;
  localparam int unsigned PW    = ABITS + 1;  // pointer width, one wrap bit
  localparam int unsigned LW    = ABITS + 2;  // level width, holds DEPTH + 2

  localparam logic [PW-1:0] RAM_FULL = PW'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DBITS-1:0] mem_q [DEPTH];
  logic [DBITS-1:0] rdata_q;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             inflight_q, inflight_d;

  logic [DBITS-1:0] ob_mem_q [2];
  logic [DBITS-1:0] ob_mem_d [2];
  logic             ob_head_q, ob_head_d;
  logic [1:0]       ob_count_q, ob_count_d;

  // ---------------------------------------------------------------------------
  // Handshakes and fetch decision
  // ---------------------------------------------------------------------------
  logic [PW-1:0] ram_count;
  logic          push;
  logic          pop;
  logic          fetch;
  logic          ob_wr;
  logic          ob_tail;
  logic [2:0]    ob_pending;
  logic [2:0]    ob_room;

  // Pointer difference is taken modulo 2**(ABITS+1); the extra wrap bit is
  // what distinguishes a full RAM (count = DEPTH) from an empty one.
  assign ram_count = wr_ptr_q - rd_ptr_q;

  // Only registered state plus the reset/flush inputs: no path from m_ready_i.
  assign s_ready_o = (ram_count != RAM_FULL) && !rst_i && !clear_i;

  assign m_valid_o = (ob_count_q != 2'd0);
  assign m_data_o  = ob_mem_q[ob_head_q];

  assign push = s_valid_i && s_ready_o;
  assign pop  = m_valid_o && m_ready_i;

  // Words already committed to the OB (held or arriving next edge) must leave
  // room for one more; a pop this cycle frees one extra slot, which is what
  // lets a full OB keep streaming at one word per cycle.
  assign ob_pending = {1'b0, ob_count_q} + {2'b00, inflight_q};
  assign ob_room    = 3'd2 + {2'b00, pop};
  assign fetch      = (ram_count != '0) && (ob_pending < ob_room) && !clear_i;

  // The RAM read issued last cycle is available now and goes to the OB tail.
  assign ob_wr = inflight_q;

  // Tail slot = head + count (mod 2).  With count 2 the tail aliases the head,
  // which is only written when that head is being popped the same cycle.
  assign ob_tail = ob_head_q ^ ob_count_q[0];

  assign level_o = LW'(ram_count) + LW'(inflight_q) + LW'(ob_count_q);

  // ---------------------------------------------------------------------------
  // RAM: full-word write, registered read, read-during-write returns old data.
  // A fetch only ever targets an address whose write edge has already passed,
  // so no bypass is needed.
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array and its read register have no reset so the tools can
  // map them onto block RAM; stale contents are never observed because the
  // pointers and inflight flag, which are reset, gate every use.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[ABITS-1:0]] <= s_data_i;
    end
    if (fetch) begin
      rdata_q <= mem_q[rd_ptr_q[ABITS-1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here is given a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = 1'b0;
    ob_head_d  = ob_head_q;
    ob_count_d = ob_count_q;
    ob_mem_d   = ob_mem_q;

    if (clear_i) begin
      // Flush: pointers equal, in-flight read dropped, OB emptied.  The RAM
      // and OB storage keep their old data; it is unreachable afterwards.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ob_head_d  = 1'b0;
      ob_count_d = 2'd0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (fetch) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      inflight_d = fetch;

      if (ob_wr) begin
        ob_mem_d[ob_tail] = rdata_q;
      end
      if (pop) begin
        ob_head_d = ~ob_head_q;
      end
      // Simultaneous pop and OB write leave the count unchanged.
      ob_count_d = ob_count_q + 2'(ob_wr) - 2'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge, independent of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      ob_head_q   <= 1'b0;
      ob_count_q  <= 2'd0;
      ob_mem_q[0] <= '0;
      ob_mem_q[1] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      ob_head_q  <= ob_head_d;
      ob_count_q <= ob_count_d;
      ob_mem_q   <= ob_mem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  // The OB never holds more than two words.
  a_ob_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
    ob_count_q != 2'd3);

  // The fetch rule guarantees a free OB slot whenever read data arrives.
  a_ob_space_on_write: assert property (@(posedge clk_i) disable iff (rst_i)
    inflight_q |-> (ob_count_q != 2'd2));

  // The RAM never reports more words than it can hold.
  a_ram_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
    ram_count <= RAM_FULL);

endmodule

// File: tb/tb_rl_fifo_1r1w_fwft.sv
// -----------------------------------------------------------------------------
// tb_rl_fifo_1r1w_fwft
//
// Scoreboard bench for rl_fifo_1r1w_fwft (ABITS=4, DBITS=32).  The reference
// model is a plain queue of accepted words: a word enters when the write
// handshake completes and leaves when the read handshake completes, so the
// model occupancy is exactly the word count the FIFO must report.  Inputs are
// driven 1 time unit after the rising edge; the monitor samples on the
// falling edge and accounts for the handshakes that the next rising edge
// will complete.
// -----------------------------------------------------------------------------
module tb_rl_fifo_1r1w_fwft;

  localparam int ABITS = 4;
  localparam int DBITS = 32;
  localparam int DEPTH = 2 ** ABITS;
  localparam int CAP   = DEPTH + 2;

  logic             clk_i;
  logic             rst_i;
  logic             clear_i;
  logic             s_valid_i;
  logic [DBITS-1:0] s_data_i;
  logic             s_ready_o;
  logic             m_valid_o;
  logic [DBITS-1:0] m_data_o;
  logic             m_ready_i;
  logic [ABITS+1:0] level_o;

  rl_fifo_1r1w_fwft #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_i),
    .s_valid_i (s_valid_i),
    .s_data_i  (s_data_i),
    .s_ready_o (s_ready_o),
    .m_valid_o (m_valid_o),
    .m_data_o  (m_data_o),
    .m_ready_i (m_ready_i),
    .level_o   (level_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [DBITS-1:0] sb [$];   // words accepted and not yet delivered

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic             hold_prev  = 1'b0;
  logic [DBITS-1:0] hold_data  = '0;
  logic             flush_prev = 1'b0;

  always @(negedge clk_i) begin
    // Occupancy always equals words accepted minus words delivered.
    check("level", 64'(level_o), 64'(sb.size()));
    if (sb.size() == 0) check("valid_when_empty", 64'(m_valid_o), 64'd0);

    if (flush_prev) check("valid_after_flush", 64'(m_valid_o), 64'd0);

    if (rst_i) begin
      check("ready_in_reset", 64'(s_ready_o), 64'd0);
    end else if (!clear_i && sb.size() < DEPTH) begin
      // Fewer than DEPTH words in total means the RAM cannot be full.
      check("ready_with_room", 64'(s_ready_o), 64'd1);
    end
    if (sb.size() >= CAP) check("ready_at_capacity", 64'(s_ready_o), 64'd0);

    // A stalled head word must stay put until it is taken.
    if (hold_prev && !flush_prev) begin
      check("stall_valid", 64'(m_valid_o), 64'd1);
      check("stall_data", 64'(m_data_o), 64'(hold_data));
    end

    if (rst_i || clear_i) begin
      sb.delete();
    end else begin
      if (m_valid_o && m_ready_i) begin
        if (sb.size() == 0) check("pop_with_empty_model", 64'(m_valid_o), 64'd0);
        else                check("data", 64'(m_data_o), 64'(sb.pop_front()));
      end
      if (s_valid_i && s_ready_o) sb.push_back(s_data_i);
    end

    hold_prev  = m_valid_o && !m_ready_i && !rst_i && !clear_i;
    hold_data  = m_data_o;
    flush_prev = rst_i || clear_i;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drain(input string name, input int max_cyc);
    bit done = 1'b0;
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk_i);
      if (sb.size() == 0 && level_o == '0) done = 1'b1;
      step();
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic run_random(input string name, input int words, input int max_cyc);
    int pushed = 0;
    int c = 0;
    while (pushed < words && c < max_cyc) begin
      s_valid_i = 1'($urandom_range(0, 1));
      s_data_i  = $urandom;
      m_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      if (s_valid_i && s_ready_o) pushed++;
      step();
      c++;
    end
    s_valid_i = 1'b0;
    check(name, 64'(pushed), 64'(words));
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int  outs, gaps, stalls, accepted;
    bit  started, stop, got;

    rst_i     = 1'b1;
    clear_i   = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    m_ready_i = 1'b0;
    repeat (3) step();
    check("reset_valid", 64'(m_valid_o), 64'd0);
    check("reset_data", 64'(m_data_o), 64'd0);
    check("reset_level", 64'(level_o), 64'd0);
    check("reset_ready", 64'(s_ready_o), 64'd0);
    rst_i = 1'b0;
    step();
    check("ready_after_reset", 64'(s_ready_o), 64'd1);

    // Single word: push ends cycle 0, head appears in cycle 3.
    s_valid_i = 1'b1;
    s_data_i  = 32'hA5A5_0001;
    m_ready_i = 1'b1;
    step();
    s_valid_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      if (k < 3)  check($sformatf("single_valid_c%0d", k), 64'(m_valid_o), 64'd0);
      if (k == 3) begin
        check("single_valid_c3", 64'(m_valid_o), 64'd1);
        check("single_data_c3", 64'(m_data_o), 64'h0000_0000_A5A5_0001);
      end
      check($sformatf("single_level_c%0d", k), 64'(level_o), (k < 4) ? 64'd1 : 64'd0);
      step();
    end

    // Streaming: 100 back-to-back words, consumer always ready.
    outs = 0; gaps = 0; stalls = 0; started = 1'b0;
    for (int c = 0; c < 300 && outs < 100; c++) begin
      s_valid_i = (c < 100);
      s_data_i  = 32'(c);
      m_ready_i = 1'b1;
      @(negedge clk_i);
      if (c < 100 && !s_ready_o) stalls++;
      if (m_valid_o) begin
        started = 1'b1;
        outs++;
      end else if (started) begin
        gaps++;
      end
      step();
    end
    s_valid_i = 1'b0;
    check("stream_outputs", 64'(outs), 64'd100);
    check("stream_gaps", 64'(gaps), 64'd0);
    check("stream_ready_stalls", 64'(stalls), 64'd0);
    drain("stream_drain", 20);

    // Fill under backpressure: RAM plus OB take exactly DEPTH + 2 words.
    m_ready_i = 1'b0;
    accepted = 0; stop = 1'b0;
    for (int c = 0; c < 60 && !stop; c++) begin
      s_valid_i = 1'b1;
      s_data_i  = $urandom;
      @(negedge clk_i);
      if (s_ready_o) accepted++;
      else           stop = 1'b1;
      step();
    end
    s_valid_i = 1'b0;
    check("fill_accepted", 64'(accepted), 64'(CAP));
    @(negedge clk_i);
    check("fill_level", 64'(level_o), 64'(CAP));
    step();
    drain("fill_drain", 60);

    // Random traffic across many pointer wraps.
    run_random("random_words", 1000, 20000);
    drain("random_drain", 60);

    // Flush with a read in flight: 6 in, 1 out, then clear.
    m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = 32'hF000_0000 + 32'(i);
      step();
    end
    s_valid_i = 1'b0;
    repeat (4) step();
    m_ready_i = 1'b1;
    step();
    clear_i = 1'b1;
    @(negedge clk_i);
    check("flush_pre_level", 64'(level_o), 64'd5);
    step();
    clear_i   = 1'b0;
    m_ready_i = 1'b0;
    @(negedge clk_i);
    check("flush_valid", 64'(m_valid_o), 64'd0);
    check("flush_level", 64'(level_o), 64'd0);
    step();
    s_valid_i = 1'b1;
    s_data_i  = 32'h0000_1234;
    step();
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk_i);
      if (m_valid_o) begin
        got = 1'b1;
        check("flush_next_word", 64'(m_data_o), 64'h1234);
      end
      step();
    end
    check("flush_next_word_seen", 64'(got), 64'd1);
    drain("flush_drain", 20);

    // Reset in the middle of traffic.
    m_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = 32'hBEEF_0000 + 32'(i);
      step();
    end
    s_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_ready_c1", 64'(s_ready_o), 64'd0);
    step();
    @(negedge clk_i);
    check("midrst_ready_c2", 64'(s_ready_o), 64'd0);
    check("midrst_valid", 64'(m_valid_o), 64'd0);
    check("midrst_level", 64'(level_o), 64'd0);
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_ready_after", 64'(s_ready_o), 64'd1);
    check("midrst_level_after", 64'(level_o), 64'd0);
    step();
    run_random("post_reset_words", 40, 2000);
    drain("post_reset_drain", 60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global bound so the run always ends on its own.
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
